clk_switch_ctrl: RTL and testbench
==================================

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter DET_WIN, default 16: number of clk cycles in the target-clock liveness window.
REQ-002 Parameter MIN_EDGES, default 2: number of target-clock rising edges required in the window to pass the liveness check.
REQ-003 Parameter SETTLE, default 8: number of clk cycles held in SETTLE after sel changes, before done is raised.
REQ-004 Port clk, input, 1: free-running controller clock; all outputs are synchronous to clk.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port clk0, input, 1: candidate clock 0, monitored only and never used to clock controller outputs.
REQ-007 Port clk1, input, 1: candidate clock 1, monitored only.
REQ-008 Port req, input, 1: switch request, sampled on the clk rising edge.
REQ-009 Port req_sel, input, 1: target clock index; valid when req=1.
REQ-010 Port sel, output, 1: registered select that drives the downstream glitch-free clock mux.
REQ-011 Port busy, output, 1: high while a request is in progress.
REQ-012 Port done, output, 1: one-cycle pulse; the request completed and sel equals the target.
REQ-013 Port err, output, 1: one-cycle pulse; the target clock failed the liveness check and sel is unchanged.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CHECK, SETTLE and RESP.
REQ-015 IDLE with req=1 and req_sel==sel: the next state SHALL be RESP with done set; no liveness check is made.
REQ-016 IDLE with req=1 and req_sel!=sel: the block SHALL latch the target, clear the window counter and the edge counter, set busy, and go to CHECK.
REQ-017 CHECK: the window counter SHALL increment each clk cycle; the edge counter SHALL increment on each edge pulse from the target monitor and saturate at MIN_EDGES.
REQ-018 CHECK exits in the cycle the window counter reaches DET_WIN-1:
- edge count >= MIN_EDGES: sel SHALL load the target on that edge, the SETTLE counter SHALL clear, and the next state SHALL be SETTLE.
- otherwise: the next state SHALL be RESP with err set.
REQ-019 SETTLE SHALL last exactly SETTLE cycles and then go to RESP with done set.
REQ-020 RESP SHALL last one cycle, assert exactly one of done or err, clear busy, and return to IDLE; a req in that cycle SHALL be ignored.
REQ-021 busy SHALL be high in CHECK, SETTLE and RESP and low in IDLE; it is registered and rises on the first clk edge after an accepted req.
REQ-022 Any req or req_sel change while busy=1 SHALL be ignored and SHALL have no effect on the latched target.
REQ-023 Latency, from the req edge:
- done for a real switch is 1+DET_WIN+SETTLE cycles.
- done for the no-op case (REQ-015) is 1 cycle.
- err is 1+DET_WIN cycles.
REQ-024 sel SHALL change only on the CHECK->SETTLE transition.
REQ-025 Each monitor SHALL contain a toggle flop clocked by clkN and reset asynchronously by rst, followed by a 2-flop synchronizer and an edge-detect register in the clk domain.
REQ-026 Each monitor SHALL emit one clk-cycle pulse per toggle transition, which is one per clkN rising edge.
REQ-027 Edge counting is specified accurate only for f_clkN <= f_clk/2; a stopped clkN SHALL produce zero pulses.
REQ-028 Counters SHALL be sized $clog2 of their terminal value plus 1 and SHALL NOT wrap.

Reset
REQ-029 While rst=0, the following SHALL hold:
- state=IDLE, sel=0, busy=0, done=0, err=0;
- all counters=0, and all toggle, synchronizer and edge registers=0.
REQ-030 A reset asserted mid-request SHALL abort the request immediately and produce no done or err pulse; sel returns to 0.
REQ-031 Reset deassertion is synchronized externally; the first req after reset is accepted normally.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the default values of DET_WIN, MIN_EDGES and SETTLE.
REQ-033 A sub-module clk_alive_mon SHALL implement the toggle flop, synchronizer and edge pulse, and SHALL be instantiated once per candidate clock.

Verification
REQ-034 Scenario 1: clk=100MHz, clk1=25MHz, req=1 with req_sel=1 for one cycle.
- sel=1 at cycle 17.
- done pulse at cycle 25, busy low at cycle 26.
- err never asserted.
REQ-035 Scenario 2: clk1 held at 0, req with req_sel=1.
- err pulse at cycle 17.
- sel stays 0 and done never asserted.
REQ-036 Scenario 3: sel=0, req with req_sel=0 → done pulse 1 cycle later, busy high for exactly 1 cycle, and sel unchanged.
REQ-037 Scenario 4: during SETTLE of a 0→1 switch, req with req_sel=0 is pulsed → ignored; sel ends at 1 and exactly one done is seen.
REQ-038 Scenario 5: rst=0 asserted in CHECK at cycle 5 → immediately sel=0, busy=0, and no done or err; a new req after release completes normally.
REQ-039 Scenario 6: clk1=clk/32 (only 1 edge in 16 cycles), req with req_sel=1 → err pulse; then with clk1=clk/4, the same req → done.

Source files
------------

// File: rtl/clk_switch_ctrl_pkg.sv
// Shared types and defaults for the clock-switch controller.
package clk_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SETTLE,
    ST_RESP
  } state_e;

  localparam int unsigned DET_WIN_DEF   = 16;
  localparam int unsigned MIN_EDGES_DEF = 2;
  localparam int unsigned SETTLE_DEF    = 8;

  // Counter width able to hold its terminal value without wrapping.
  function automatic int unsigned cnt_w(input int unsigned term);
    return $clog2(term) + 1;
  endfunction

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Request/response bundle between a requester and the clock-switch controller.
interface clk_switch_ctrl_if;
  logic req;
  logic req_sel;
  logic sel;
  logic busy;
  logic done;
  logic err;

  modport master (output req, output req_sel,
                  input  sel, input busy, input done, input err);
  modport slave  (input  req, input req_sel,
                  output sel, output busy, output done, output err);
endinterface

// File: rtl/clk_switch_ctrl_alive_mon.sv
// Liveness monitor: toggles in the monitored domain, emits one clk pulse per mon_clk_i rising edge.
module clk_alive_mon (
  input  logic clk,
  input  logic rst,
  input  logic mon_clk_i,
  output logic pulse_o
);

  logic tog_q;
  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  always_ff @(posedge mon_clk_i or negedge rst) begin
    if (!rst) tog_q <= '0;
    else      tog_q <= ~tog_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= tog_q;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q ^ edge_q;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-switch controller: verifies the target clock is alive, moves sel, then settles before done.
module clk_switch_ctrl
  import clk_switch_ctrl_pkg::*;
#(
  parameter int unsigned DET_WIN   = DET_WIN_DEF,
  parameter int unsigned MIN_EDGES = MIN_EDGES_DEF,
  parameter int unsigned SETTLE    = SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk0,
  input  logic              clk1,
  clk_switch_ctrl_if.slave  bus
);

  localparam int unsigned WIN_W = cnt_w(DET_WIN - 1);
  localparam int unsigned EDG_W = cnt_w(MIN_EDGES);
  localparam int unsigned STL_W = cnt_w(SETTLE - 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DET_WIN - 1);
  localparam logic [EDG_W-1:0] EDG_MIN  = EDG_W'(MIN_EDGES);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE - 1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tgt_q, tgt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [EDG_W-1:0] edg_q, edg_d;
  logic [STL_W-1:0] stl_q, stl_d;

  logic             pulse0;
  logic             pulse1;
  logic             tgt_pulse;
  logic [EDG_W-1:0] edg_nx;

  clk_alive_mon u_mon0 (
    .clk       (clk),
    .rst       (rst),
    .mon_clk_i (clk0),
    .pulse_o   (pulse0)
  );

  clk_alive_mon u_mon1 (
    .clk       (clk),
    .rst       (rst),
    .mon_clk_i (clk1),
    .pulse_o   (pulse1)
  );

  assign tgt_pulse = tgt_q ? pulse1 : pulse0;
  // The final window cycle's pulse still counts toward the decision.
  assign edg_nx    = (tgt_pulse && (edg_q != EDG_MIN)) ? edg_q + EDG_W'(1) : edg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      tgt_q   <= '0;
      win_q   <= '0;
      edg_q   <= '0;
      stl_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tgt_q   <= tgt_d;
      win_q   <= win_d;
      edg_q   <= edg_d;
      stl_q   <= stl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tgt_d   = tgt_q;
    win_d   = win_q;
    edg_d   = edg_q;
    stl_d   = stl_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (bus.req_sel == sel_q) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
          end else begin
            tgt_d   = bus.req_sel;
            win_d   = '0;
            edg_d   = '0;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        edg_d = edg_nx;
        if (win_q == WIN_LAST) begin
          if (edg_nx >= EDG_MIN) begin
            sel_d   = tgt_q;
            stl_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_SETTLE: begin
        if (stl_q == STL_LAST) begin
          done_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          stl_d = stl_q + STL_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl with a request-level reference model.
`timescale 1ns/1ps
module tb_clk_switch_ctrl;

  localparam int DW = 16;
  localparam int SW = 8;
  localparam int ME = 2;

  logic clk = 1'b0;
  logic rst;
  logic clk0 = 1'b0;
  logic clk1 = 1'b0;
  int   p0 = 0;
  int   p1 = 0;

  int checks = 0;
  int errors = 0;
  bit m_sel  = 1'b0;

  clk_switch_ctrl_if bus_if();

  clk_switch_ctrl #(
    .DET_WIN   (DW),
    .MIN_EDGES (ME),
    .SETTLE    (SW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .clk0 (clk0),
    .clk1 (clk1),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // Candidate clocks: period in clk cycles (0 = stopped), edges offset from clk edges.
  initial begin
    #2;
    forever begin
      if (p0 == 0) begin clk0 = 1'b0; #10; end
      else begin #(p0 * 5); clk0 = ~clk0; end
    end
  end

  initial begin
    #2;
    forever begin
      if (p1 == 0) begin clk1 = 1'b0; #10; end
      else begin #(p1 * 5); clk1 = ~clk1; end
    end
  end

  function automatic bit alive(input int p);
    return (p != 0) && ((DW / p) >= ME);
  endfunction

  function automatic logic [3:0] obs();
    return {bus_if.sel, bus_if.busy, bus_if.done, bus_if.err};
  endfunction

  task automatic set_clks(input int n0, input int n1);
    p0 = n0;
    p1 = n1;
    repeat (100) @(negedge clk);
  endtask

  // One request; optional injected req pulse at cycle inj_c (1..L) while busy.
  task automatic run_req(input bit tgt, input bit inj_en, input int inj_r,
                         input bit inj_sel, input string name);
    bit         sw, ok, nsel;
    int         lat, inj_c;
    logic [3:0] exp_v, got;
    sw    = (tgt != m_sel);
    ok    = !sw || alive(tgt ? p1 : p0);
    lat   = !sw ? 1 : (ok ? 1 + DW + SW : 1 + DW);
    inj_c = inj_en ? 1 + (inj_r % lat) : 0;
    @(negedge clk);
    bus_if.req     = 1'b1;
    bus_if.req_sel = tgt;
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      nsel  = (sw && ok && c >= DW + 1) ? tgt : m_sel;
      exp_v = {nsel, (c <= lat), (c == lat) && ok, (c == lat) && !ok};
      got   = obs();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d {sel,busy,done,err}: got %b expected %b", name, c, got, exp_v);
      end
      bus_if.req     = (c == inj_c);
      bus_if.req_sel = (c == inj_c) ? inj_sel : 1'($urandom);
    end
    bus_if.req = 1'b0;
    if (sw && ok) m_sel = tgt;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus_if.req     = 1'($urandom);
      bus_if.req_sel = 1'($urandom);
      checks++;
      if (obs() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold: got %b expected 0000", obs());
      end
    end
    bus_if.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_sel = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b expected 0000", obs());
    end
  endtask

  task automatic test_switch;
    set_clks(4, 4);
    run_req(1'b1, 1'b0, 0, 1'b0, "switch_0to1");
    run_req(1'b0, 1'b0, 0, 1'b0, "switch_1to0");
  endtask

  task automatic test_dead_clock;
    set_clks(4, 0);
    run_req(1'b1, 1'b0, 0, 1'b0, "dead_clk1");
  endtask

  task automatic test_noop;
    run_req(m_sel, 1'b0, 0, 1'b0, "noop");
  endtask

  task automatic test_busy_ignore;
    set_clks(4, 4);
    run_req(1'b1, 1'b1, 19, 1'b0, "ignore_in_settle");
    run_req(1'b0, 1'b1, 2, 1'b1, "ignore_in_check");
    run_req(1'b1, 1'b1, 24, 1'b0, "ignore_in_resp");
  endtask

  task automatic test_reset_mid;
    set_clks(4, 4);
    if (m_sel == 1'b0) run_req(1'b1, 1'b0, 0, 1'b0, "reset_mid_prep");
    @(negedge clk);
    bus_if.req     = 1'b1;
    bus_if.req_sel = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus_if.req = 1'b0;
      checks++;
      if (obs() !== 4'b1100) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d: got %b expected 1100", c, obs());
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_immediate: got %b expected 0000", obs());
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_sel = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_after cycle %0d: got %b expected 0000", c, obs());
      end
    end
    run_req(1'b1, 1'b0, 0, 1'b0, "reset_mid_new_req");
  endtask

  task automatic test_slow_clock;
    set_clks(4, 4);
    if (m_sel == 1'b1) run_req(1'b0, 1'b0, 0, 1'b0, "slow_prep");
    set_clks(4, 32);
    run_req(1'b1, 1'b0, 0, 1'b0, "slow_clk32_err");
    set_clks(4, 4);
    run_req(1'b1, 1'b0, 0, 1'b0, "slow_clk4_done");
  endtask

  task automatic test_random;
    int periods [6] = '{0, 2, 4, 8, 32, 64};
    for (int i = 0; i < 12; i++) begin
      set_clks(periods[$urandom_range(0, 5)], periods[$urandom_range(0, 5)]);
      run_req(1'($urandom), 1'($urandom), int'($urandom_range(0, 40)),
              1'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back;
    set_clks(8, 2);
    run_req(~m_sel, 1'b0, 0, 1'b0, "b2b_a");
    run_req(~m_sel, 1'b0, 0, 1'b0, "b2b_b");
    run_req(m_sel, 1'b0, 0, 1'b0, "b2b_noop");
  endtask

  initial begin
    bus_if.req     = 1'b0;
    bus_if.req_sel = 1'b0;
    p0 = 4;
    p1 = 4;
    test_reset();
    test_switch();
    test_dead_clock();
    test_noop();
    test_busy_ignore();
    test_reset_mid();
    test_slow_clock();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
